// File: rtl/pulse_sync_deb_if.sv
// pulse_sync_deb_if: channel-side signals of the pulse conditioner, with master (driver) and slave (conditioner) views
interface pulse_sync_deb_if #(
  parameter int CH_NUM = 4,
  parameter int OVR_W = 8
);
  logic [CH_NUM-1:0] Gc_in_level;
  logic [CH_NUM-1:0] Gc_mode;
  logic Gc_clr_ovr;
  logic [CH_NUM-1:0] Gc_out_pulse;
  logic [CH_NUM-1:0] Gc_busy;
  logic [CH_NUM-1:0] Gc_ovr_flag;
  logic [CH_NUM*OVR_W-1:0] Gc_ovr_cnt;
  modport master (
    output Gc_in_level, Gc_mode, Gc_clr_ovr,
    input Gc_out_pulse, Gc_busy, Gc_ovr_flag, Gc_ovr_cnt
  );
  modport slave (
    input Gc_in_level, Gc_mode, Gc_clr_ovr,
    output Gc_out_pulse, Gc_busy, Gc_ovr_flag, Gc_ovr_cnt
  );
endinterface

// File: rtl/pulse_sync_deb.sv
// pulse_sync_deb: per-channel synchronise, edge detect, debounce, delay and single-cycle pulse with overrun tracking.
// Define PULSE_SYNC_OVR_CNT_EN to build the saturating overrun counters; otherwise Gc_ovr_cnt is tied to 0.
module pulse_sync_deb #(
  parameter int CH_NUM = 4,
  parameter int SYNC_STG = 2,
  parameter int VAL_DEB = 3,
  parameter int VAL_DEL = 4,
  parameter int OVR_W = 8
) (
  input logic Gc_clk125,
  input logic Gc_rst_n,
  pulse_sync_deb_if.slave bus
);
  localparam int VMAX = VAL_DEB > VAL_DEL ? VAL_DEB : VAL_DEL;
  localparam int CW = VMAX < 1 ? 1 : $clog2(VMAX + 1);
  typedef enum logic [1:0] {IDLE, DEB, DLY, PULSE} state_t;
  localparam state_t ST_ENTRY = state_t'(VAL_DEB > 0 ? DEB : VAL_DEL > 0 ? DLY : PULSE);
  localparam state_t ST_POST_DEB = state_t'(VAL_DEL > 0 ? DLY : PULSE);
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    state_t st, st_nx;
    logic [SYNC_STG-1:0] sync;
    logic [CW-1:0] cnt, cnt_nx;
    logic s, sp, lv, lv_nx, edge_det, ovr_ev, pulse, busy, flag;
    assign s = sync[SYNC_STG-1];
    assign edge_det = bus.Gc_mode[i] ? s ^ sp : s & ~sp;
    always_ff @(posedge Gc_clk125 or negedge Gc_rst_n)
      if (!Gc_rst_n) begin
        sync <= '0;
        sp <= 1'b0;
        st <= IDLE;
        cnt <= '0;
        lv <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STG-2:0], bus.Gc_in_level[i]};
        sp <= s;
        st <= st_nx;
        cnt <= cnt_nx;
        lv <= lv_nx;
      end
    always_comb begin
      st_nx = st;
      cnt_nx = cnt;
      lv_nx = lv;
      case (st)
        IDLE:
          if (edge_det) begin
            st_nx = ST_ENTRY;
            cnt_nx = '0;
            lv_nx = s;
          end
        DEB:
          if (s != lv) st_nx = IDLE;
          else if (cnt == CW'(VAL_DEB - 1)) begin
            st_nx = ST_POST_DEB;
            cnt_nx = '0;
          end else cnt_nx = cnt + 1'b1;
        DLY:
          if (cnt == CW'(VAL_DEL - 1)) begin
            st_nx = PULSE;
            cnt_nx = '0;
          end else cnt_nx = cnt + 1'b1;
        default: st_nx = IDLE;
      endcase
    end
    // An edge arriving after debounce has committed cannot be queued, so it is reported instead
    always_comb begin
      pulse = st == PULSE;
      busy = st != IDLE;
      ovr_ev = edge_det && (st == DLY || st == PULSE);
    end
    always_ff @(posedge Gc_clk125 or negedge Gc_rst_n)
      if (!Gc_rst_n) flag <= 1'b0;
      else flag <= ovr_ev | (flag & ~bus.Gc_clr_ovr);
    assign bus.Gc_out_pulse[i] = pulse;
    assign bus.Gc_busy[i] = busy;
    assign bus.Gc_ovr_flag[i] = flag;
`ifdef PULSE_SYNC_OVR_CNT_EN
    logic [OVR_W-1:0] oc;
    always_ff @(posedge Gc_clk125 or negedge Gc_rst_n)
      if (!Gc_rst_n) oc <= '0;
      else if (ovr_ev) oc <= bus.Gc_clr_ovr ? OVR_W'(1) : oc + OVR_W'(~&oc);
      else if (bus.Gc_clr_ovr) oc <= '0;
    assign bus.Gc_ovr_cnt[i*OVR_W +: OVR_W] = oc;
`else
    assign bus.Gc_ovr_cnt[i*OVR_W +: OVR_W] = '0;
`endif
  end
endmodule

// File: tb/tb_pulse_sync_deb.sv
// tb_pulse_sync_deb: directed and random stimulus, timeline reference model feeding a scoreboard queue
module tb_pulse_sync_deb;
  localparam int CH = 4, SS = 2, D = 3, L = 4, OW = 8;
  localparam int SAT = 2**OW - 1;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  pulse_sync_deb_if #(.CH_NUM(CH), .OVR_W(OW)) bus();
  pulse_sync_deb #(.CH_NUM(CH), .SYNC_STG(SS), .VAL_DEB(D), .VAL_DEL(L), .OVR_W(OW)) dut (
    .Gc_clk125(clk),
    .Gc_rst_n(rst_n),
    .bus(bus)
  );
  typedef struct {
    logic [CH-1:0] pulse;
    logic [CH-1:0] busy;
    logic [CH-1:0] flag;
    logic [CH*OW-1:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  logic [CH-1:0] hist[$];
  int t;
  int acc[CH];
  int oc[CH];
  int pcnt[CH] = '{default: 0};
  logic lv[CH];
  logic fl[CH];
  int nchk = 0, npass = 0;
  task automatic chk(string n, logic [63:0] a, logic [63:0] x);
    nchk++;
    if (a === x) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
  endtask
  // Synchronised level after edge k is the raw sample taken SS-1 edges earlier
  function automatic logic sv(int k, int c);
    int i = k - SS + 1;
    return (i >= 0) ? hist[i][c] : 1'b0;
  endfunction
  function automatic void mreset();
    hist.delete();
    exp_q.delete();
    t = 0;
    for (int c = 0; c < CH; c++) begin
      acc[c] = -1;
      oc[c] = 0;
      fl[c] = 1'b0;
      lv[c] = 1'b0;
    end
  endfunction
  // acc = edge index at which the channel accepted its edge; pulse due at acc+D+L
  function automatic void step();
    exp_t e;
    logic clr;
    e.pulse = '0;
    e.busy = '0;
    e.flag = '0;
    e.cnt = '0;
    clr = bus.Gc_clr_ovr;
    hist.push_back(bus.Gc_in_level);
    for (int c = 0; c < CH; c++) begin
      logic s1, s2, ed, ov;
      s1 = sv(t - 1, c);
      s2 = sv(t - 2, c);
      ed = bus.Gc_mode[c] ? (s1 ^ s2) : (s1 & ~s2);
      ov = 1'b0;
      if (acc[c] < 0) begin
        if (ed) begin
          acc[c] = t;
          lv[c] = s1;
        end
      end else if (t <= acc[c] + D) begin
        if (s1 != lv[c]) acc[c] = -1;
      end else begin
        ov = ed;
        if (t - 1 == acc[c] + D + L) acc[c] = -1;
      end
      e.pulse[c] = acc[c] >= 0 && t == acc[c] + D + L;
      e.busy[c] = acc[c] >= 0;
      fl[c] = ov ? 1'b1 : clr ? 1'b0 : fl[c];
      oc[c] = ov ? (clr ? 1 : (oc[c] < SAT ? oc[c] + 1 : oc[c])) : clr ? 0 : oc[c];
      e.flag[c] = fl[c];
`ifdef PULSE_SYNC_OVR_CNT_EN
      e.cnt[c*OW +: OW] = OW'(oc[c]);
`endif
    end
    exp_q.push_back(e);
    t++;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mreset();
    else step();
  always @(negedge clk)
    if (!rst_n)
      chk("reset_outputs", {bus.Gc_out_pulse, bus.Gc_busy, bus.Gc_ovr_flag, bus.Gc_ovr_cnt}, '0);
    else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("out_pulse", bus.Gc_out_pulse, cur.pulse);
      chk("busy", bus.Gc_busy, cur.busy);
      chk("ovr_flag", bus.Gc_ovr_flag, cur.flag);
      chk("ovr_cnt", bus.Gc_ovr_cnt, cur.cnt);
      for (int c = 0; c < CH; c++) if (bus.Gc_out_pulse[c]) pcnt[c]++;
    end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ovr3(int gap);
    bus.Gc_in_level[3] = ~bus.Gc_in_level[3];
    tick(6);
    bus.Gc_in_level[3] = ~bus.Gc_in_level[3];
    tick(gap);
  endtask
  initial begin
    logic [OW-1:0] c_one, c_sat;
`ifdef PULSE_SYNC_OVR_CNT_EN
    c_one = OW'(1);
    c_sat = OW'(SAT);
`else
    c_one = '0;
    c_sat = '0;
`endif
    bus.Gc_in_level = '0;
    bus.Gc_mode = '0;
    bus.Gc_clr_ovr = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    bus.Gc_in_level[0] = 1'b1;
    tick(20);
    bus.Gc_in_level[0] = 1'b0;
    tick(20);
    chk("ch0_pulse_count", pcnt[0], 1);
    bus.Gc_in_level[1] = 1'b1;
    tick(2);
    bus.Gc_in_level[1] = 1'b0;
    tick(20);
    chk("ch1_glitch_pulses", pcnt[1], 0);
    chk("ch1_flag", bus.Gc_ovr_flag[1], 1'b0);
    bus.Gc_mode[2] = 1'b1;
    repeat (4) begin
      bus.Gc_in_level[2] = ~bus.Gc_in_level[2];
      tick(20);
    end
    chk("ch2_toggle_pulses", pcnt[2], 4);
    bus.Gc_mode[3] = 1'b1;
    ovr3(20);
    chk("ch3_pulses", pcnt[3], 1);
    chk("ch3_flag", bus.Gc_ovr_flag[3], 1'b1);
    chk("ch3_cnt_one", bus.Gc_ovr_cnt[3*OW +: OW], c_one);
    repeat (299) ovr3(6);
    tick(20);
    chk("ch3_cnt_sat", bus.Gc_ovr_cnt[3*OW +: OW], c_sat);
    bus.Gc_in_level[3] = ~bus.Gc_in_level[3];
    tick(6);
    bus.Gc_in_level[3] = ~bus.Gc_in_level[3];
    tick(2);
    bus.Gc_clr_ovr = 1'b1;
    tick(1);
    bus.Gc_clr_ovr = 1'b0;
    chk("clr_vs_event_cnt", bus.Gc_ovr_cnt[3*OW +: OW], c_one);
    chk("clr_vs_event_flag", bus.Gc_ovr_flag[3], 1'b1);
    chk("clr_other_cnt", bus.Gc_ovr_cnt[3*OW-1:0], '0);
    tick(20);
    bus.Gc_mode[0] = 1'b0;
    bus.Gc_in_level[0] = 1'b1;
    tick(6);
    bus.Gc_in_level[0] = 1'b0;
    tick(2);
    chk("ch0_busy_before_reset", bus.Gc_busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {bus.Gc_out_pulse, bus.Gc_busy, bus.Gc_ovr_flag, bus.Gc_ovr_cnt}, '0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("ch0_no_pulse_after_reset", pcnt[0], 1);
    repeat (3000) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) bus.Gc_in_level[c] = ~bus.Gc_in_level[c];
        if ($urandom_range(0, 39) == 0) bus.Gc_mode[c] = ~bus.Gc_mode[c];
      end
      bus.Gc_clr_ovr = $urandom_range(0, 49) == 0;
      tick(1);
    end
    bus.Gc_clr_ovr = 1'b0;
    tick(30);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
